// File: rtl/crisp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crisp_pkg
// Description : Shared types and constants for the integer writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
package crisp_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [4:0]      reg_idx_t;

  // One buffered load response: destination register and returned data.
  typedef struct packed {
    reg_idx_t rd;
    word_t    data;
  } lq_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous FIFO of load-queue entries. DEPTH must be a power
//               of two; pointers wrap naturally and the count carries one
//               extra bit so that full and empty are distinguishable.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import crisp_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  lq_entry_t  push_entry,
  input  logic       pop,
  output lq_entry_t  head,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  lq_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Storage array: written on push only, contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_unit.sv
`default_nettype none
// ============================================================================
// Module      : wb_unit
// Description : Writeback unit. Merges single-cycle ALU results with queued
//               load responses into one registered register-file write per
//               cycle (ALU has priority), and keeps a per-register mask of
//               outstanding loads for decode stalls.
//               Optional feature macro: WB_SCOREBOARD_EN enables the busy
//               mask; when undefined busy is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_unit
  import crisp_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [4:0]                alu_rd,
  input  logic [31:0]               alu_data,
  input  logic                      ld_issue,
  input  logic [4:0]                ld_issue_rd,
  input  logic                      ld_resp_valid,
  output logic                      ld_resp_ready,
  input  logic [4:0]                ld_resp_rd,
  input  logic [31:0]               ld_resp_data,
  output logic                      alu_stall,
  output logic                      rf_write_en,
  output logic [4:0]                rf_rd_select,
  output logic [31:0]               rf_data,
  output logic [31:0]               busy,
  output logic [$clog2(LQ_DEPTH):0] lq_count
);

  logic      q_full;
  logic      q_empty;
  logic      push;
  logic      pop;
  lq_entry_t head;
  lq_entry_t push_entry;

  logic      sel_valid;
  reg_idx_t  sel_rd;
  word_t     sel_data;

  // Readiness depends on state only; a pop this cycle does not reopen it.
  assign ld_resp_ready = !q_full;
  assign alu_stall     = q_full;
  assign push          = ld_resp_valid && ld_resp_ready;
  assign push_entry    = '{rd: ld_resp_rd, data: ld_resp_data};

  // The queue head drains only in cycles the ALU leaves the write port free.
  assign pop = !alu_valid && !q_empty;

  wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (lq_count)
  );

  // Source selection: ALU first, then queue head, else nothing.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (!q_empty) begin
      sel_valid = 1'b1;
      sel_rd    = head.rd;
      sel_data  = head.data;
    end
  end

  // Register-file write port; address and data hold when no real write occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_en  <= 1'b0;
      rf_rd_select <= '0;
      rf_data      <= '0;
    end else begin
      rf_write_en <= sel_valid && (sel_rd != '0);
      if (sel_valid && (sel_rd != '0)) begin
        rf_rd_select <= sel_rd;
        rf_data      <= sel_data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_next;

  // Clear on load pop, then set on issue so a same-register set wins; x0 never busy.
  always_comb begin
    busy_next = busy_q;
    if (pop) begin
      busy_next[head.rd] = 1'b0;
    end
    if (ld_issue && (ld_issue_rd != '0)) begin
      busy_next[ld_issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Busy mask register, cleared asynchronously with the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{ld_issue, ld_issue_rd};
  assign busy         = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_unit
// Description : Directed self-checking bench for wb_unit. Busy expectations
//               follow WB_SCOREBOARD_EN (all-zero when it is undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_resp_valid;
  logic        ld_resp_ready;
  logic [4:0]  ld_resp_rd;
  logic [31:0] ld_resp_data;
  logic        alu_stall;
  logic        rf_write_en;
  logic [4:0]  rf_rd_select;
  logic [31:0] rf_data;
  logic [31:0] busy;
  logic [1:0]  lq_count;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  wb_unit #(
    .LQ_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .ld_issue      (ld_issue),
    .ld_issue_rd   (ld_issue_rd),
    .ld_resp_valid (ld_resp_valid),
    .ld_resp_ready (ld_resp_ready),
    .ld_resp_rd    (ld_resp_rd),
    .ld_resp_data  (ld_resp_data),
    .alu_stall     (alu_stall),
    .rf_write_en   (rf_write_en),
    .rf_rd_select  (rf_rd_select),
    .rf_data       (rf_data),
    .busy          (busy),
    .lq_count      (lq_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected busy mask: the given bits when the scoreboard is built, else zero.
  function automatic logic [31:0] bexp(input logic [31:0] mask);
`ifdef WB_SCOREBOARD_EN
    return mask;
`else
    return 32'h0 & mask;
`endif
  endfunction

  // Advance one cycle; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic resp(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ld_resp_valid = v; ld_resp_rd = rd; ld_resp_data = d;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd);
    ld_issue = v; ld_issue_rd = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    alu(0, 0, 0); resp(0, 0, 0); issue(0, 0);
    #2;
    check("rst_we",    {31'b0, rf_write_en},  32'd0);
    check("rst_rd",    {27'b0, rf_rd_select}, 32'd0);
    check("rst_data",  rf_data,               32'd0);
    check("rst_busy",  busy,                  32'd0);
    check("rst_count", {30'b0, lq_count},     32'd0);
    check("rst_ready", {31'b0, ld_resp_ready}, 32'd1);
    check("rst_stall", {31'b0, alu_stall},    32'd0);
    #10 rst_n = 1'b1;
    tick();

    // ALU write appears on the next edge
    alu(1, 5, 32'hDEADBEEF);
    tick();
    alu(0, 0, 0);
    check("alu_we",   {31'b0, rf_write_en},  32'd1);
    check("alu_rd",   {27'b0, rf_rd_select}, 32'd5);
    check("alu_data", rf_data,               32'hDEADBEEF);
    tick();
    check("idle_we",   {31'b0, rf_write_en},  32'd0);
    check("idle_hold", {27'b0, rf_rd_select}, 32'd5);

    // Load issue sets busy, response writes two cycles later and clears it
    issue(1, 7);
    tick();
    issue(0, 0);
    check("busy_set7", busy, bexp(32'h0000_0080));
    resp(1, 7, 32'h1234);
    tick();
    resp(0, 0, 0);
    check("ld_q1",  {30'b0, lq_count},    32'd1);
    check("ld_we0", {31'b0, rf_write_en}, 32'd0);
    tick();
    check("ld_we",    {31'b0, rf_write_en},  32'd1);
    check("ld_rd",    {27'b0, rf_rd_select}, 32'd7);
    check("ld_data",  rf_data,               32'h1234);
    check("busy_clr7", busy,                 32'd0);
    check("ld_q0",    {30'b0, lq_count},     32'd0);

    // Contention: two ALU cycles delay the queued load
    resp(1, 9, 32'hAAAA);
    tick();
    resp(0, 0, 0);
    alu(1, 1, 32'h11);
    tick();
    check("cont_rd1", {27'b0, rf_rd_select}, 32'd1);
    check("cont_q_a", {30'b0, lq_count},     32'd1);
    alu(1, 2, 32'h22);
    tick();
    check("cont_rd2",  {27'b0, rf_rd_select}, 32'd2);
    check("cont_d2",   rf_data,               32'h22);
    check("cont_q_b",  {30'b0, lq_count},     32'd1);
    alu(0, 0, 0);
    tick();
    check("cont_ld_we", {31'b0, rf_write_en},  32'd1);
    check("cont_ld_rd", {27'b0, rf_rd_select}, 32'd9);
    check("cont_ld_d",  rf_data,               32'hAAAA);
    check("cont_q0",    {30'b0, lq_count},     32'd0);

    // Full queue under continuous ALU traffic
    alu(1, 4, 32'h40);
    resp(1, 10, 32'hA);
    tick();
    resp(1, 11, 32'hB);
    tick();
    check("full_q2",    {30'b0, lq_count},      32'd2);
    check("full_ready", {31'b0, ld_resp_ready}, 32'd0);
    check("full_stall", {31'b0, alu_stall},     32'd1);
    resp(1, 12, 32'hC);
    tick();
    check("full_hold_q", {30'b0, lq_count}, 32'd2);
    check("full_alu_rd", {27'b0, rf_rd_select}, 32'd4);
    alu(0, 0, 0);
    tick();
    check("drain_q1",    {30'b0, lq_count},      32'd1);
    check("drain_ready", {31'b0, ld_resp_ready}, 32'd1);
    check("drain_rd",    {27'b0, rf_rd_select},  32'd10);
    check("drain_data",  rf_data,                32'hA);
    resp(0, 0, 0);
    tick();
    check("drain2_rd",   {27'b0, rf_rd_select},  32'd11);
    check("drain2_data", rf_data,                32'hB);
    check("drain2_q0",   {30'b0, lq_count},      32'd0);

    // x0 response pops without writing
    resp(1, 0, 32'h5555);
    tick();
    resp(0, 0, 0);
    check("x0_q1", {30'b0, lq_count}, 32'd1);
    tick();
    check("x0_we",   {31'b0, rf_write_en},  32'd0);
    check("x0_q0",   {30'b0, lq_count},     32'd0);
    check("x0_hold", {27'b0, rf_rd_select}, 32'd11);

    // Set wins over a same-register clear
    issue(1, 3);
    resp(1, 3, 32'h33);
    tick();
    resp(0, 0, 0);
    check("sw_busy_pre", busy, bexp(32'h0000_0008));
    tick();
    issue(0, 0);
    check("sw_we",   {31'b0, rf_write_en},  32'd1);
    check("sw_rd",   {27'b0, rf_rd_select}, 32'd3);
    check("sw_busy", busy, bexp(32'h0000_0008));
    tick();
    check("sw_busy_hold", busy, bexp(32'h0000_0008));

    // Reset mid-operation with two entries queued
    alu(1, 6, 32'h66);
    resp(1, 13, 32'hD);
    tick();
    resp(1, 14, 32'hE);
    tick();
    resp(0, 0, 0);
    check("pre_rst_q2", {30'b0, lq_count}, 32'd2);
    #2 rst_n = 1'b0;
    alu(0, 0, 0);
    #1;
    check("arst_q0",    {30'b0, lq_count},      32'd0);
    check("arst_busy",  busy,                   32'd0);
    check("arst_we",    {31'b0, rf_write_en},   32'd0);
    check("arst_ready", {31'b0, ld_resp_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_we", {31'b0, rf_write_en}, 32'd0);
      check("post_rst_q",  {30'b0, lq_count},    32'd0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
`default_nettype wire
